// File: rtl/serial_word_comparator.sv
// Byte-serial magnitude comparator: folds MSB-first A/B byte pairs into a
// less/equal/greater cascade and publishes one registered verdict per word.
module serial_word_comparator #(
  parameter int NBYTES = 4,
  parameter int SIGNED = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       byte_valid,
  input  logic [7:0] a_byte,
  input  logic [7:0] b_byte,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       lt,
  output logic       et,
  output logic       gt
);

  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {C_EQ, C_LT, C_GT} casc_t;

  state_t        r_state;
  state_t        w_nextState;
  casc_t         r_casc;
  casc_t         w_nextCasc;
  logic [CW-1:0] r_count;
  logic          r_lt;
  logic          r_et;
  logic          r_gt;
  logic          w_accept;
  logic          w_lastByte;
  logic          w_byteLt;
  logic          w_byteGt;

  assign w_accept   = byte_valid && (r_state == S_RUN);
  assign w_lastByte = (r_count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (w_accept && w_lastByte) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Only the most significant byte carries the sign, so the signed compare
  // applies to the first pair of the word alone.
  always_comb begin
    if ((SIGNED != 0) && (r_count == '0)) begin
      w_byteLt = $signed(a_byte) < $signed(b_byte);
      w_byteGt = $signed(a_byte) > $signed(b_byte);
    end else begin
      w_byteLt = a_byte < b_byte;
      w_byteGt = a_byte > b_byte;
    end
  end

  always_comb begin
    w_nextCasc = r_casc;
    if (r_casc == C_EQ) begin
      if (w_byteLt) begin
        w_nextCasc = C_LT;
      end else if (w_byteGt) begin
        w_nextCasc = C_GT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_casc  <= C_EQ;
      r_count <= '0;
      r_lt    <= 1'b0;
      r_et    <= 1'b0;
      r_gt    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_casc  <= C_EQ;
        r_count <= '0;
      end else if (w_accept) begin
        r_casc  <= w_nextCasc;
        r_count <= r_count + CW'(1);
        // Verdict is loaded on the edge entering DONE so it is valid with done.
        if (w_lastByte) begin
          r_lt <= (w_nextCasc == C_LT);
          r_et <= (w_nextCasc == C_EQ);
          r_gt <= (w_nextCasc == C_GT);
        end
      end
    end
  end

  assign lt = r_lt;
  assign et = r_et;
  assign gt = r_gt;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed self-checking bench: an unsigned and a signed instance share the
// same byte stream so sign handling is observed side by side.
module tb_serial_word_comparator;

  logic       clk;
  logic       rst;
  logic       start;
  logic       byte_valid;
  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic       ready, busy, done, lt, et, gt;
  logic       readyS, busyS, doneS, ltS, etS, gtS;

  int checks;
  int failures;
  int latency;

  serial_word_comparator #(.NBYTES(4), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .a_byte(a_byte), .b_byte(b_byte), .ready(ready), .busy(busy),
    .done(done), .lt(lt), .et(et), .gt(gt)
  );

  serial_word_comparator #(.NBYTES(4), .SIGNED(1)) u_dutSigned (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .a_byte(a_byte), .b_byte(b_byte), .ready(readyS), .busy(busyS),
    .done(doneS), .lt(ltS), .et(etS), .gt(gtS)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one word from the negedge that raises start; returns the number of
  // negedges from that point until done is seen (-1 if never seen).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int stallBefore, input int stallLen,
                               input bit pokeStart, output int lat);
    int  cyc;
    bit  seen;
    @(negedge clk);
    start      = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == stallBefore) begin
        for (int s = 0; s < stallLen; s++) begin
          byte_valid = 1'b0;
          start      = pokeStart;
          @(negedge clk);
          cyc++;
          start = 1'b0;
        end
      end
      checkOutput("run_ready", {31'd0, ready}, 32'd1);
      byte_valid = 1'b1;
      a_byte     = a[31-8*i -: 8];
      b_byte     = b[31-8*i -: 8];
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    lat = seen ? cyc : -1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    a_byte     = 8'h00;
    b_byte     = 8'h00;
    #12;
    checkOutput("reset_outs", {26'd0, ready, busy, done, lt, et, gt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // byte_valid in IDLE must not start anything
    byte_valid = 1'b1;
    a_byte     = 8'h55;
    b_byte     = 8'h11;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_ignore", {28'd0, ready, busy, done, gt}, 32'd0);
    byte_valid = 1'b0;

    // Last byte decides
    applyStimulus(32'h12345678, 32'h12345679, 99, 0, 1'b0, latency);
    checkOutput("basic_latency", latency, 32'd5);
    checkOutput("basic_verdict", {29'd0, lt, et, gt}, 32'b100);
    checkOutput("basic_signed", {29'd0, ltS, etS, gtS}, 32'b100);
    @(negedge clk);
    checkOutput("basic_hold", {29'd0, lt, et, gt}, 32'b100);

    // Equal words plus done-cycle handshake flags
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 99, 0, 1'b0, latency);
    checkOutput("eq_verdict", {29'd0, lt, et, gt}, 32'b010);
    checkOutput("eq_signed", {29'd0, ltS, etS, gtS}, 32'b010);
    checkOutput("eq_done_flags", {29'd0, done, ready, busy}, 32'b101);
    @(negedge clk);
    checkOutput("eq_after_busy", {30'd0, busy, done}, 32'd0);

    // First byte decides even though later bytes point the other way
    applyStimulus(32'h01FFFFFF, 32'h02000000, 99, 0, 1'b0, latency);
    checkOutput("early_verdict", {29'd0, lt, et, gt}, 32'b100);
    checkOutput("early_latency", latency, 32'd5);

    // Sign bit in the first byte
    applyStimulus(32'hFF000000, 32'h7FFFFFFF, 99, 0, 1'b0, latency);
    checkOutput("sign_unsigned", {29'd0, lt, et, gt}, 32'b001);
    checkOutput("sign_signed", {29'd0, ltS, etS, gtS}, 32'b100);

    // Stall between bytes 2 and 3 with a stray start pulse
    applyStimulus(32'h12345678, 32'h12345679, 2, 3, 1'b1, latency);
    checkOutput("stall_latency", latency, 32'd8);
    checkOutput("stall_verdict", {29'd0, lt, et, gt}, 32'b100);
    @(negedge clk);
    checkOutput("stall_idle", {30'd0, busy, ready}, 32'd0);

    // Reset after two accepted pairs
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b1;
    a_byte     = 8'h10;
    b_byte     = 8'h10;
    @(negedge clk);
    a_byte = 8'h20;
    b_byte = 8'h20;
    @(negedge clk);
    byte_valid = 1'b0;
    checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrun_reset", {26'd0, ready, busy, done, lt, et, gt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h00000000, 32'h00000000, 99, 0, 1'b0, latency);
    checkOutput("post_reset_latency", latency, 32'd5);
    checkOutput("post_reset_verdict", {29'd0, lt, et, gt}, 32'b010);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
